stream_demux1_3: RTL and testbench

STREAM_DEMUX1_3 -- requirements
Module: stream_demux1_3

---
 rtl/stream_demux1_3.sv | 97 +++++++++
 tb/tb_stream_demux1_3.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/stream_demux1_3.sv
// rtl/stream_demux1_3.sv - 1-to-3 stream demux with a 2-entry FIFO per channel
// Select 2'b11 is accepted and dropped, latching a sticky err_sel.
module stream_demux1_3 #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic [1:0]        in_sel,
  output logic              outA_valid,
  input  logic              outA_ready,
  output logic [DWIDTH-1:0] outA_data,
  output logic              outB_valid,
  input  logic              outB_ready,
  output logic [DWIDTH-1:0] outB_data,
  output logic              outC_valid,
  input  logic              outC_ready,
  output logic [DWIDTH-1:0] outC_data,
  output logic              err_sel
);

  logic [2:0]        w_full;
  logic [2:0]        w_valid;
  logic [2:0]        w_push;
  logic [2:0]        w_pop;
  logic [2:0]        w_out_ready;
  logic [DWIDTH-1:0] w_head [3];
  logic              w_accept;
  logic              r_err;

  assign w_out_ready = {outC_ready, outB_ready, outA_ready};

  // Illegal select is always accepted so a bad word never stalls upstream.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (in_sel)
        2'b00:   in_ready = !w_full[0];
        2'b01:   in_ready = !w_full[1];
        2'b10:   in_ready = !w_full[2];
        default: in_ready = 1'b1;
      endcase
    end
  end

  assign w_accept = in_valid && in_ready;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [1:0]        r_count;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [DWIDTH-1:0] r_mem [2];

    assign w_push[c]  = w_accept && (in_sel == 2'(c));
    assign w_pop[c]   = w_valid[c] && w_out_ready[c];
    assign w_valid[c] = (r_count != 2'd0);
    assign w_full[c]  = (r_count == 2'd2);
    assign w_head[c]  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_count  <= 2'd0;
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
      end else begin
        if (w_push[c]) r_wr_ptr <= ~r_wr_ptr;
        if (w_pop[c])  r_rd_ptr <= ~r_rd_ptr;
        case ({w_push[c], w_pop[c]})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end

    // Storage is deliberately left unreset; valid gates its visibility.
    always_ff @(posedge clk) begin
      if (w_push[c]) r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_err <= 1'b0;
    else if (w_accept && in_sel == 2'b11)   r_err <= 1'b1;
  end

  assign err_sel    = r_err;
  assign outA_valid = w_valid[0];
  assign outB_valid = w_valid[1];
  assign outC_valid = w_valid[2];
  assign outA_data  = w_head[0];
  assign outB_data  = w_head[1];
  assign outC_data  = w_head[2];

endmodule

// File: tb/tb_stream_demux1_3.sv
// tb/tb_stream_demux1_3.sv - scoreboard bench for stream_demux1_3
// Stimulus pushes expected words per channel; a negedge monitor pops and compares.
module tb_stream_demux1_3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [1:0]  in_sel = 2'b00;
  logic        outA_valid, outB_valid, outC_valid;
  logic        outA_ready = 1'b0, outB_ready = 1'b0, outC_ready = 1'b0;
  logic [31:0] outA_data, outB_data, outC_data;
  logic        err_sel;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] q_c[$];

  stream_demux1_3 #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .outA_valid(outA_valid), .outA_ready(outA_ready), .outA_data(outA_data),
    .outB_valid(outB_valid), .outB_ready(outB_ready), .outB_data(outB_data),
    .outC_valid(outC_valid), .outC_ready(outC_ready), .outC_data(outC_data),
    .err_sel(err_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic mon_one(input string name, input logic v, input logic r,
                         input logic [31:0] d, inout logic [31:0] q[$]);
    if (v) begin
      if (q.size() == 0) begin
        check({name, " unexpected word"}, d, 32'hxxxx_xxxx);
      end else begin
        check({name, " data"}, d, q[0]);
        if (r) void'(q.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_one("chA", outA_valid, outA_ready, outA_data, q_a);
      mon_one("chB", outB_valid, outB_ready, outB_data, q_b);
      mon_one("chC", outC_valid, outC_ready, outC_data, q_c);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] s, input logic [31:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send timeout", 32'd0, 32'd1);
    else begin
      case (s)
        2'b00:   q_a.push_back(d);
        2'b01:   q_b.push_back(d);
        2'b10:   q_c.push_back(d);
        default: ;
      endcase
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    check("rst outA_valid", {31'd0, outA_valid}, 32'd0);
    check("rst outB_valid", {31'd0, outB_valid}, 32'd0);
    check("rst outC_valid", {31'd0, outC_valid}, 32'd0);
    check("rst err_sel",    {31'd0, err_sel},    32'd0);
    check("rst in_ready",   {31'd0, in_ready},   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Single route to B, held by backpressure
    send(2'b01, 32'hDEADBEEF);
    check("route outB_valid", {31'd0, outB_valid}, 32'd1);
    check("route outB_data",  outB_data, 32'hDEADBEEF);
    check("route outA_valid", {31'd0, outA_valid}, 32'd0);
    check("route outC_valid", {31'd0, outC_valid}, 32'd0);
    idle(2);
    outB_ready = 1'b1;
    idle(2);
    outB_ready = 1'b0;

    // Fill A, A blocked but C still open
    send(2'b00, 32'h1);
    send(2'b00, 32'h2);
    in_sel = 2'b00; #1;
    check("A full in_ready", {31'd0, in_ready}, 32'd0);
    in_sel = 2'b10; #1;
    check("C open in_ready", {31'd0, in_ready}, 32'd1);
    idle(1);
    outA_ready = 1'b1;
    idle(3);
    check("A drained valid", {31'd0, outA_valid}, 32'd0);
    outA_ready = 1'b0;

    // Concurrent push and pop at count 1
    send(2'b00, 32'h5);
    outA_ready = 1'b1;
    send(2'b00, 32'h6);
    outA_ready = 1'b0;
    check("pushpop valid", {31'd0, outA_valid}, 32'd1);
    check("pushpop head",  outA_data, 32'h6);
    idle(2);
    outA_ready = 1'b1;
    idle(2);
    check("pushpop drained", {31'd0, outA_valid}, 32'd0);

    // Illegal select
    in_sel = 2'b11; #1;
    check("illegal in_ready", {31'd0, in_ready}, 32'd1);
    check("err before", {31'd0, err_sel}, 32'd0);
    send(2'b11, 32'hABCD);
    check("err_sel set", {31'd0, err_sel}, 32'd1);
    check("illegal no valid", {29'd0, outC_valid, outB_valid, outA_valid}, 32'd0);
    idle(4);
    check("err_sel sticky", {31'd0, err_sel}, 32'd1);

    // Interleave with all ready; each word is head one cycle after acceptance
    outA_ready = 1'b1; outB_ready = 1'b1; outC_ready = 1'b1;
    send(2'b10, 32'h10);
    check("ilv C0 head", outC_data, 32'h10);
    send(2'b01, 32'h11);
    check("ilv B head", outB_data, 32'h11);
    send(2'b10, 32'h12);
    check("ilv C1 head", outC_data, 32'h12);
    check("ilv C1 valid", {31'd0, outC_valid}, 32'd1);
    idle(3);

    // Reset mid-operation with B and C full
    outB_ready = 1'b0; outC_ready = 1'b0;
    send(2'b01, 32'h21);
    send(2'b01, 32'h22);
    send(2'b10, 32'h31);
    send(2'b10, 32'h32);
    check("pre-rst full B", {31'd0, outB_valid}, 32'd1);
    #2;
    rst = 1'b1;
    q_b.delete();
    q_c.delete();
    #1;
    check("mid rst valids", {29'd0, outC_valid, outB_valid, outA_valid}, 32'd0);
    check("mid rst err_sel", {31'd0, err_sel}, 32'd0);
    check("mid rst in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(2'b01, 32'h77);
    check("post-rst outB_data", outB_data, 32'h77);
    outB_ready = 1'b1; outC_ready = 1'b1;
    idle(3);

    check("q_a empty", q_a.size(), 32'd0);
    check("q_b empty", q_b.size(), 32'd0);
    check("q_c empty", q_c.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
